// File: rtl/drive_command_gen_if.sv
// Operator inputs and drive command outputs of drive_command_gen.
// The master side is the command generator; the slave side is the board/display.
interface drive_command_gen_if;
    logic [3:0] key_n;
    logic       sw_run;
    logic [1:0] sw_dir;
    logic [1:0] instruction;
    logic [2:0] torque;
    logic       enable;
    logic       read_enable;
    logic [1:0] state;

    modport master (
        input  key_n, sw_run, sw_dir,
        output instruction, torque, enable, read_enable, state
    );

    modport slave (
        output key_n, sw_run, sw_dir,
        input  instruction, torque, enable, read_enable, state
    );
endinterface

// File: rtl/drive_command_gen.sv
// Debounces operator keys, runs the drive-mode FSM and releases direction/torque
// commands once per update tick, together with a read_enable strobe.
module drive_command_gen #(
    parameter int TICK_DIV        = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int ESTOP_TICKS     = 2
) (
    input  logic                clk,
    input  logic                reset,
    drive_command_gen_if.master bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int EW = (ESTOP_TICKS > 1) ? $clog2(ESTOP_TICKS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE   = TW'(TICK_DIV - 2);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [EW-1:0] ESTOP_LAST = EW'(ESTOP_TICKS - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DRIVE = 2'b01;
    localparam logic [1:0] ST_COAST = 2'b10;
    localparam logic [1:0] ST_ESTOP = 2'b11;

    localparam logic [1:0] DIR_FWD    = 2'b00;
    localparam logic [1:0] DIR_REV    = 2'b01;
    localparam logic [2:0] TORQUE_MAX = 3'd4;

    function automatic logic [2:0] torque_inc(input logic [2:0] t);
        return (t >= TORQUE_MAX) ? TORQUE_MAX : t + 3'd1;
    endfunction

    function automatic logic [2:0] torque_dec(input logic [2:0] t);
        return (t == 3'd0) ? 3'd0 : t - 3'd1;
    endfunction

    function automatic logic is_reversal(input logic [1:0] from_dir, input logic [1:0] to_dir);
        return ((from_dir == DIR_FWD) && (to_dir == DIR_REV)) ||
               ((from_dir == DIR_REV) && (to_dir == DIR_FWD));
    endfunction

    logic [2:0]    key_p0, key_p1;
    logic          run_p0, run_p1;
    logic [1:0]    dir_p0, dir_p1;
    logic [DW-1:0] db_cnt [3];
    logic [2:0]    db_level;
    logic [2:0]    press;
    logic [2:0]    pending;
    logic [TW-1:0] tick_cnt;
    logic          strobe;
    logic          update;
    logic [1:0]    state_q;
    logic [1:0]    instr_q;
    logic [2:0]    torque_q;
    logic          enable_q;
    logic [EW-1:0] estop_cnt;
    logic          unused_key;

    assign unused_key = bus.key_n[3];

    // Stage p0/p1: two-flop synchronizers for every asynchronous input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_p0 <= 3'b111;
            key_p1 <= 3'b111;
            run_p0 <= 1'b0;
            run_p1 <= 1'b0;
            dir_p0 <= 2'b00;
            dir_p1 <= 2'b00;
        end else begin
            key_p0 <= bus.key_n[2:0];
            key_p1 <= key_p0;
            run_p0 <= bus.sw_run;
            run_p1 <= run_p0;
            dir_p0 <= bus.sw_dir;
            dir_p1 <= dir_p0;
        end
    end

    // A press is the debounced level falling on the cycle its counter expires
    always_comb begin
        press = 3'b000;
        for (int i = 0; i < 3; i++) begin
            press[i] = db_level[i] && !key_p1[i] && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
            db_level <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (key_p1[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= key_p1[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Flags consumed in the update cycle; a press landing in that cycle survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 3'b000;
        end else if (update) begin
            pending <= press;
        end else begin
            pending <= pending | press;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            strobe   <= 1'b0;
            update   <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
            strobe   <= (tick_cnt == TICK_PRE);
            update   <= (tick_cnt == TICK_LAST);
        end
    end

    // Drive-mode FSM; emergency stop overrides everything outside IDLE/ESTOP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= DIR_FWD;
            torque_q  <= 3'd0;
            enable_q  <= 1'b0;
            estop_cnt <= '0;
        end else if (update) begin
            if (pending[2] && ((state_q == ST_DRIVE) || (state_q == ST_COAST))) begin
                state_q   <= ST_ESTOP;
                instr_q   <= DIR_REV;
                torque_q  <= TORQUE_MAX;
                enable_q  <= 1'b1;
                estop_cnt <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (run_p1) begin
                            state_q  <= ST_DRIVE;
                            enable_q <= 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        if (!run_p1) begin
                            state_q <= ST_COAST;
                        end else begin
                            if (pending[0] && !pending[1]) begin
                                torque_q <= torque_inc(torque_q);
                            end else if (pending[1] && !pending[0]) begin
                                torque_q <= torque_dec(torque_q);
                            end
                            // A reversal only takes effect once the wheel torque is already zero
                            if (!is_reversal(instr_q, dir_p1) || (torque_q == 3'd0)) begin
                                instr_q <= dir_p1;
                            end
                        end
                    end
                    ST_COAST: begin
                        if (run_p1) begin
                            state_q <= ST_DRIVE;
                        end else if (torque_q == 3'd0) begin
                            state_q  <= ST_IDLE;
                            enable_q <= 1'b0;
                            instr_q  <= DIR_FWD;
                        end else begin
                            torque_q <= torque_dec(torque_q);
                        end
                    end
                    ST_ESTOP: begin
                        if (estop_cnt == ESTOP_LAST) begin
                            state_q   <= ST_IDLE;
                            instr_q   <= DIR_FWD;
                            torque_q  <= 3'd0;
                            enable_q  <= 1'b0;
                            estop_cnt <= '0;
                        end else begin
                            estop_cnt <= estop_cnt + EW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.instruction = instr_q;
    assign bus.torque      = torque_q;
    assign bus.enable      = enable_q;
    assign bus.read_enable = strobe;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_drive_command_gen.sv
// Bench for drive_command_gen: reset/tick timing, a directed vector table,
// hand-built corner sequences and randomized ticks against a tick-level model.
module tb_drive_command_gen;
    localparam int TICK_DIV        = 16;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int ESTOP_TICKS     = 2;

    logic clk = 1'b0;
    logic reset;

    drive_command_gen_if bus ();

    drive_command_gen #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ESTOP_TICKS    (ESTOP_TICKS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic [1:0] dir;
        logic [2:0] keys;
        logic [1:0] st;
        logic [1:0] instr;
        logic [2:0] tq;
        logic       en;
    } vec_t;

    vec_t vecs[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int m_st, m_instr, m_tq, m_en, m_ecnt;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int observed();
        return {24'd0, bus.state, bus.instruction, bus.torque, bus.enable};
    endfunction

    function automatic int model_word();
        return (m_st << 6) | (m_instr << 4) | (m_tq << 1) | m_en;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_instr = 0; m_tq = 0; m_en = 0; m_ecnt = 0;
    endfunction

    // One update tick of the drive rules, given the keys pressed during the tick
    function automatic void model_tick(input logic run, input logic [1:0] dir, input logic [2:0] keys);
        int  old_tq = m_tq;
        int  d      = int'(dir);
        bit  rev;
        if (keys[2] && (m_st == 1 || m_st == 2)) begin
            m_st = 3; m_instr = 1; m_tq = 4; m_en = 1; m_ecnt = 0;
            return;
        end
        case (m_st)
            0: if (run) begin m_st = 1; m_en = 1; end
            1: begin
                if (!run) begin
                    m_st = 2;
                end else begin
                    if (keys[0] && !keys[1]) m_tq = (m_tq < 4) ? m_tq + 1 : 4;
                    if (keys[1] && !keys[0]) m_tq = (m_tq > 0) ? m_tq - 1 : 0;
                    rev = (m_instr < 2) && (d < 2) && (m_instr != d);
                    if (!rev || old_tq == 0) m_instr = d;
                end
            end
            2: begin
                if (run) m_st = 1;
                else if (m_tq == 0) begin m_st = 0; m_en = 0; m_instr = 0; end
                else m_tq = m_tq - 1;
            end
            default: begin
                m_ecnt++;
                if (m_ecnt >= ESTOP_TICKS) begin
                    m_st = 0; m_en = 0; m_tq = 0; m_instr = 0; m_ecnt = 0;
                end
            end
        endcase
    endfunction

    // Entered just after an update; holds keys for 'hold' cycles and returns just after the next update
    task automatic step(input logic run, input logic [1:0] dir, input logic [2:0] keys, input int hold);
        bit seen = 1'b0;
        bus.sw_run = run;
        bus.sw_dir = dir;
        bus.key_n  = {1'b1, ~keys};
        repeat (hold) @(posedge clk);
        #1 bus.key_n = 4'hF;
        for (int i = 0; i < 2 * TICK_DIV && !seen; i++) begin
            @(posedge clk);
            #1 seen = bus.read_enable;
        end
        check("strobe_seen", int'(seen), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic run, input logic [1:0] dir, input logic [2:0] keys,
                                input logic [1:0] st, input logic [1:0] instr, input logic [2:0] tq,
                                input logic en);
        vecs.push_back('{run, dir, keys, st, instr, tq, en});
    endfunction

    initial begin
        add(1, 0, 3'b000, 1, 0, 0, 1);
        add(1, 0, 3'b001, 1, 0, 1, 1);
        add(1, 0, 3'b001, 1, 0, 2, 1);
        add(1, 0, 3'b001, 1, 0, 3, 1);
        add(1, 0, 3'b001, 1, 0, 4, 1);
        add(1, 0, 3'b001, 1, 0, 4, 1);
        add(1, 0, 3'b001, 1, 0, 4, 1);
        add(1, 0, 3'b010, 1, 0, 3, 1);
        add(1, 1, 3'b000, 1, 0, 3, 1);
        add(1, 1, 3'b010, 1, 0, 2, 1);
        add(1, 1, 3'b010, 1, 0, 1, 1);
        add(1, 1, 3'b010, 1, 0, 0, 1);
        add(1, 1, 3'b000, 1, 1, 0, 1);
        add(1, 1, 3'b001, 1, 1, 1, 1);
        add(1, 1, 3'b011, 1, 1, 1, 1);
        add(1, 2, 3'b001, 1, 2, 2, 1);
        add(1, 2, 3'b001, 1, 2, 3, 1);
        add(1, 2, 3'b001, 1, 2, 4, 1);
        add(0, 2, 3'b000, 2, 2, 4, 1);
        add(0, 2, 3'b001, 2, 2, 3, 1);
        add(0, 2, 3'b000, 2, 2, 2, 1);
        add(1, 2, 3'b000, 1, 2, 2, 1);
        add(0, 2, 3'b000, 2, 2, 2, 1);
        add(0, 2, 3'b000, 2, 2, 1, 1);
        add(0, 2, 3'b000, 2, 2, 0, 1);
        add(0, 2, 3'b000, 0, 0, 0, 0);
        add(0, 0, 3'b100, 0, 0, 0, 0);
        add(1, 0, 3'b000, 1, 0, 0, 1);
        add(1, 0, 3'b001, 1, 0, 1, 1);
        add(1, 3, 3'b100, 3, 1, 4, 1);
        add(0, 2, 3'b100, 3, 1, 4, 1);
        add(1, 0, 3'b001, 0, 0, 0, 0);
        add(1, 0, 3'b000, 1, 0, 0, 1);

        reset      = 1'b1;
        bus.key_n  = 4'hF;
        bus.sw_run = 1'b0;
        bus.sw_dir = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("in_reset_outputs", observed(), 0);
        check("in_reset_read_enable", int'(bus.read_enable), 0);
        @(negedge clk) reset = 1'b0;

        // Strobe lands on count TICK_DIV-1 of every period; outputs stay idle with run low
        #1 check("tick_k0_read_enable", int'(bus.read_enable), 0);
        check("tick_k0_outputs", observed(), 0);
        for (int k = 1; k <= 3 * TICK_DIV; k++) begin
            @(posedge clk);
            #1 check($sformatf("tick_k%0d_read_enable", k), int'(bus.read_enable),
                     ((k % TICK_DIV) == TICK_DIV - 1) ? 1 : 0);
            check($sformatf("tick_k%0d_outputs", k), observed(), 0);
        end
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].run, vecs[i].dir, vecs[i].keys, 7);
            model_tick(vecs[i].run, vecs[i].dir, vecs[i].keys);
            check($sformatf("table[%0d]", i), observed(),
                  {24'd0, vecs[i].st, vecs[i].instr, vecs[i].tq, vecs[i].en});
        end

        // A two-cycle key bounce must not register as a press
        step(1, 0, 3'b001, 7);
        model_tick(1, 0, 3'b001);
        check("glitch_setup", observed(), 8'h43);
        step(1, 0, 3'b001, 2);
        check("glitch_ignored", observed(), 8'h43);

        for (int n = 0; n < 60; n++) begin
            logic       run;
            logic [1:0] dir;
            logic [2:0] keys;
            run  = ($urandom_range(0, 4) != 0);
            dir  = 2'($urandom_range(0, 3));
            keys = {($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            step(run, dir, keys, 7);
            model_tick(run, dir, keys);
            check($sformatf("random[%0d]", n), observed(), model_word());
        end

        // Reset pulsed in the middle of an emergency stop
        step(1, 0, 3'b000, 7);
        model_tick(1, 0, 3'b000);
        step(1, 0, 3'b100, 7);
        model_tick(1, 0, 3'b100);
        check("estop_entered", observed(), model_word());
        check("estop_state", int'(bus.state), 3);
        repeat (3) @(posedge clk);
        bus.sw_run = 1'b0;
        #1 reset = 1'b1;
        #1 check("estop_reset_outputs", observed(), 0);
        check("estop_reset_read_enable", int'(bus.read_enable), 0);
        @(negedge clk) reset = 1'b0;
        model_reset();
        repeat (TICK_DIV + 1) @(posedge clk);
        #1 check("after_reset_idle", observed(), model_word());
        step(1, 0, 3'b000, 7);
        model_tick(1, 0, 3'b000);
        check("after_reset_drive", observed(), model_word());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
